conv_frame_sequencer: RTL and testbench

Frame-level controller for the 3x3 stride-2 convolution unit. It reads one IMG_H x IMG_W 8-bit image in raster order from a synchronous input memory, streams the pixels into the convolution unit with a valid strobe, and writes each stride-2 result to an output memory at consecutive addresses. It also clears the convolution unit before each frame and reports busy/done to the host sequencer.

---
 rtl/conv_frame_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer
//
// Frame-level controller for the 3x3 stride-2 convolution unit. It fetches one
// IMG_H x IMG_W 8-bit image in raster order from a synchronous input memory,
// streams each pixel into the convolution unit with a valid strobe, and writes
// every stride-2 result (tagged pixel at even row >= 2 and even column >= 2) to
// the output memory at consecutive addresses. The convolution unit is cleared
// for CLR_CYC cycles before each frame.
//
// Ports
//   Clk, Rst        clock (rising edge), asynchronous active-high reset
//   start           frame request, only looked at while idle
//   hold            back-pressure, freezes pixel fetch while high
//   busy, done      host status: busy from the cycle after start through done,
//                   done is a single-cycle pulse after the last write retires
//   in_rd_en/in_addr/in_data
//                   input memory read port, data arrives one cycle after rd_en
//   conv_rst        clear strobe to the convolution unit
//   conv_valid_in/conv_data_in
//                   pixel stream to the convolution unit
//   conv_data_out   convolution result, valid the cycle after its pixel
//   out_we/out_addr/out_data
//                   output memory write port
//   dbg_state       current FSM state, for observation only
//
// Strobe semantics: there is no ready path anywhere in this block. Every strobe
// (in_rd_en, conv_valid_in, out_we) transfers exactly one item in the cycle it
// is high. The only flow control is hold, which suppresses in_rd_en; a read
// already issued always completes, so valid and write strobes are never
// stalled once launched.
// -----------------------------------------------------------------------------
module conv_frame_sequencer #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int IN_AW   = 12,
    parameter int OUT_AW  = 10,
    parameter int CLR_CYC = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              in_rd_en,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [7:0]        in_data,
    output logic              conv_rst,
    output logic              conv_valid_in,
    output logic [7:0]        conv_data_in,
    input  logic [7:0]        conv_data_out,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic [2:0]        dbg_state
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int KW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic [IN_AW-1:0]    in_addr_q, in_addr_d;
    logic [OUT_AW-1:0]   out_addr_q, out_addr_d;
    logic                vld_q, vld_d;
    logic [RW-1:0]       tag_row_q, tag_row_d;
    logic [CW-1:0]       tag_col_q, tag_col_d;
    logic                we_q, we_d;

    logic                last_pix;
    logic                tag_hit;

    assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    // A stride-2 window is complete when the delayed pixel sits at an even
    // row and column, both at least 2 (the bottom-right of a 3x3 window).
    assign tag_hit = vld_q
                     && (tag_row_q >= RW'(2)) && !tag_row_q[0]
                     && (tag_col_q >= CW'(2)) && !tag_col_q[0];

    // -------------------------------------------------------------------------
    // Next-state and strobe logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        in_addr_d  = in_addr_q;
        out_addr_d = we_q ? (out_addr_q + OUT_AW'(1)) : out_addr_q;
        in_rd_en   = 1'b0;
        conv_rst   = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                clr_cnt_d = '0;
                if (start) begin
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                conv_rst   = 1'b1;
                row_d      = '0;
                col_d      = '0;
                in_addr_d  = '0;
                out_addr_d = '0;
                if (clr_cnt_q == KW'(CLR_CYC - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = S_STREAM;
                end else begin
                    clr_cnt_d = clr_cnt_q + KW'(1);
                end
            end

            S_STREAM: begin
                if (!hold) begin
                    in_rd_en = 1'b1;
                    if (last_pix) begin
                        // Counters stay on the last pixel; CLEAR rewinds them.
                        state_d = S_DRAIN;
                    end else begin
                        in_addr_d = in_addr_q + IN_AW'(1);
                        if (col_q == CW'(IMG_W - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end

            S_DRAIN: begin
                // Once the last valid has left the pipe, any write it produced
                // is on out_we now and retires at this edge.
                if (!vld_q) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        vld_d     = in_rd_en;
        tag_row_d = in_rd_en ? row_q : tag_row_q;
        tag_col_d = in_rd_en ? col_q : tag_col_q;
        we_d      = tag_hit;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Counters and pipeline registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            clr_cnt_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            vld_q      <= 1'b0;
            tag_row_q  <= '0;
            tag_col_q  <= '0;
            we_q       <= 1'b0;
        end else begin
            clr_cnt_q  <= clr_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            in_addr_q  <= in_addr_d;
            out_addr_q <= out_addr_d;
            vld_q      <= vld_d;
            tag_row_q  <= tag_row_d;
            tag_col_q  <= tag_col_d;
            we_q       <= we_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign in_addr       = in_addr_q;
    assign conv_valid_in = vld_q;
    assign conv_data_in  = in_data;
    assign out_we        = we_q;
    assign out_addr      = out_addr_q;
    assign out_data      = conv_data_out;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for conv_frame_sequencer. Two instances share the clock and reset:
// index 0 is an 8x8 frame, index 1 a 7x5 frame, both with CLR_CYC=2.
// For each frame a cycle table of expected outputs is built from the frame
// rules (read schedule with holds, one-cycle valid delay, write two cycles
// after a qualifying read, done three cycles after the last read).
// -----------------------------------------------------------------------------
module tb_conv_frame_sequencer;

  localparam int CLR  = 2;
  localparam int MAXC = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] start_v;
  logic [1:0] hold_v;

  wire  [1:0] busy_v, done_v, rd_v, crst_v, vld_v, we_v;
  wire  [11:0] iaddr_v [2];
  wire  [9:0]  oaddr_v [2];
  wire  [7:0]  cdin_v  [2];
  wire  [7:0]  odata_v [2];
  wire  [2:0]  dbg_v   [2];
  logic [7:0]  in_data_r  [2];
  logic [7:0]  conv_out_r [2];

  conv_frame_sequencer #(.IMG_W(8), .IMG_H(8), .IN_AW(12), .OUT_AW(10), .CLR_CYC(CLR)) u_seq8 (
    .Clk(clk), .Rst(rst), .start(start_v[0]), .hold(hold_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .in_rd_en(rd_v[0]), .in_addr(iaddr_v[0]),
    .in_data(in_data_r[0]), .conv_rst(crst_v[0]), .conv_valid_in(vld_v[0]),
    .conv_data_in(cdin_v[0]), .conv_data_out(conv_out_r[0]), .out_we(we_v[0]),
    .out_addr(oaddr_v[0]), .out_data(odata_v[0]), .dbg_state(dbg_v[0])
  );

  conv_frame_sequencer #(.IMG_W(7), .IMG_H(5), .IN_AW(12), .OUT_AW(10), .CLR_CYC(CLR)) u_seq75 (
    .Clk(clk), .Rst(rst), .start(start_v[1]), .hold(hold_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .in_rd_en(rd_v[1]), .in_addr(iaddr_v[1]),
    .in_data(in_data_r[1]), .conv_rst(crst_v[1]), .conv_valid_in(vld_v[1]),
    .conv_data_in(cdin_v[1]), .conv_data_out(conv_out_r[1]), .out_we(we_v[1]),
    .out_addr(oaddr_v[1]), .out_data(odata_v[1]), .dbg_state(dbg_v[1])
  );

  // Input memory and an identity "convolution": result = pixel presented
  // in the previous cycle.
  logic [7:0] mem [64];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_v[k]) in_data_r[k] <= mem[iaddr_v[k][5:0]];
      if (vld_v[k]) conv_out_r[k] <= cdin_v[k];
    end
  end

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cur_t  = 0;
  int sel    = 0;
  bit chk_en = 1'b0;

  int img_w, img_h, n_pix, last_rd, done_c, end_c;
  bit e_busy [MAXC];
  bit e_done [MAXC];
  bit e_rd   [MAXC];
  bit e_crst [MAXC];
  bit e_vld  [MAXC];
  bit e_we   [MAXC];
  int e_addr [MAXC];
  int e_pix  [MAXC];
  int e_waddr[MAXC];
  int e_wdata[MAXC];
  bit h_t    [MAXC];
  bit s_t    [MAXC];
  int hb     [64];

  logic [7:0] exp_q [$];
  logic [7:0] act_q [$];
  int first_we, first_rd, n_rd, act_done, last_waddr;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0d sel=%0d: got %0d expected %0d", nm, cur_t, sel, act, exp_v);
    end
  endtask

  task automatic clear_model();
    for (int t = 0; t < MAXC; t++) begin
      e_busy[t] = 0; e_done[t] = 0; e_rd[t] = 0; e_crst[t] = 0;
      e_vld[t] = 0; e_we[t] = 0; e_addr[t] = 0; e_pix[t] = 0;
      e_waddr[t] = 0; e_wdata[t] = 0; h_t[t] = 0; s_t[t] = 0;
    end
  endtask

  // Expected frame schedule from hb[] (hold cycles in front of each pixel)
  // and mem[].
  task automatic build_model(input int k);
    int cyc, wr, r, c;
    img_w = (k == 0) ? 8 : 7;
    img_h = (k == 0) ? 8 : 5;
    n_pix = img_w * img_h;
    clear_model();
    s_t[0] = 1;
    for (int t = 1; t <= CLR; t++) e_crst[t] = 1;
    cyc = CLR + 1;
    wr  = 0;
    for (int p = 0; p < n_pix; p++) begin
      for (int j = 0; j < hb[p]; j++) begin
        h_t[cyc] = 1;
        cyc++;
      end
      e_rd[cyc]    = 1;
      e_addr[cyc]  = p;
      e_vld[cyc+1] = 1;
      e_pix[cyc+1] = int'(mem[p]);
      r = p / img_w;
      c = p % img_w;
      if (r >= 2 && r % 2 == 0 && c >= 2 && c % 2 == 0) begin
        e_we[cyc+2]    = 1;
        e_waddr[cyc+2] = wr;
        e_wdata[cyc+2] = int'(mem[p]);
        wr++;
      end
      cyc++;
    end
    last_rd = cyc - 1;
    done_c  = last_rd + 3;
    e_done[done_c] = 1;
    for (int t = 1; t <= done_c; t++) e_busy[t] = 1;
    end_c = done_c + 2;
  endtask

  task automatic ramp_mem();
    for (int a = 0; a < 64; a++) mem[a] = 8'(a);
  endtask

  task automatic no_holds();
    for (int p = 0; p < 64; p++) hb[p] = 0;
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy",     busy_v[sel], e_busy[cur_t]);
        chk("done",     done_v[sel], e_done[cur_t]);
        chk("in_rd_en", rd_v[sel],   e_rd[cur_t]);
        chk("conv_rst", crst_v[sel], e_crst[cur_t]);
        chk("conv_vld", vld_v[sel],  e_vld[cur_t]);
        chk("out_we",   we_v[sel],   e_we[cur_t]);
        if (e_rd[cur_t])  chk("in_addr", iaddr_v[sel], e_addr[cur_t]);
        if (e_vld[cur_t]) chk("conv_data_in", cdin_v[sel], e_pix[cur_t]);
        if (e_we[cur_t]) begin
          chk("out_addr", oaddr_v[sel], e_waddr[cur_t]);
          chk("out_data", odata_v[sel], e_wdata[cur_t]);
        end
        if (rd_v[sel]) begin
          n_rd++;
          if (first_rd < 0) first_rd = cur_t;
        end
        if (we_v[sel]) begin
          act_q.push_back(odata_v[sel]);
          if (first_we < 0) first_we = cur_t;
          last_waddr = int'(oaddr_v[sel]);
        end
        if (done_v[sel] && act_done < 0) act_done = cur_t;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input int k, input string tag);
    chk({tag, "_busy"},     busy_v[k],  0);
    chk({tag, "_done"},     done_v[k],  0);
    chk({tag, "_rd"},       rd_v[k],    0);
    chk({tag, "_crst"},     crst_v[k],  0);
    chk({tag, "_vld"},      vld_v[k],   0);
    chk({tag, "_we"},       we_v[k],    0);
    chk({tag, "_in_addr"},  iaddr_v[k], 0);
    chk({tag, "_out_addr"}, oaddr_v[k], 0);
    chk({tag, "_state"},    dbg_v[k],   0);
  endtask

  // Runs the frame in the current tables. abort_addr >= 0 asserts reset in
  // the cycle that read is issued and returns with reset still high.
  task automatic run_frame(input int k, input int abort_addr);
    sel = k;
    act_q.delete();
    first_we = -1; first_rd = -1; n_rd = 0; act_done = -1; last_waddr = -1;
    for (int t = 0; t <= end_c; t++) begin
      @(posedge clk);
      #1;
      start_v[k] = s_t[t];
      hold_v[k]  = h_t[t];
      cur_t      = t;
      if (abort_addr >= 0 && e_rd[t] && e_addr[t] == abort_addr) begin
        chk_en = 1'b0;
        #1;
        chk("abort_rd_before", rd_v[k], 1);
        chk("abort_addr_before", iaddr_v[k], abort_addr);
        rst     = 1'b1;
        start_v = '0;
        hold_v  = '0;
        #1;
        check_all_zero(k, "abort");
        return;
      end
      chk_en = 1'b1;
    end
    @(negedge clk);
    #1;
    chk_en  = 1'b0;
    start_v = '0;
    hold_v  = '0;
  endtask

  task automatic expect_idle(input int k, input int n);
    clear_model();
    sel = k;
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      cur_t  = t;
      chk_en = 1'b1;
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_wr_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk({tag, "_wr_data"}, act_q[i], exp_q[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst     = 1'b1;
    start_v = '0;
    hold_v  = '0;
    ramp_mem();
    no_holds();

    // Reset values on both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero(0, "reset");
    check_all_zero(1, "reset");
    @(posedge clk);
    #1 rst = 1'b0;
    expect_idle(0, 2);

    // 8x8 frame, no hold; extra start 3 cycles later and one on the done cycle.
    build_model(0);
    s_t[3]      = 1;
    s_t[done_c] = 1;
    run_frame(0, -1);
    chk("a_first_rd_cycle", first_rd, 3);
    chk("a_rd_count", n_rd, 64);
    chk("a_first_we_cycle", first_we, 23);
    chk("a_last_out_addr", last_waddr, 8);
    chk("a_done_cycle", act_done, 69);
    exp_q = '{8'd18, 8'd20, 8'd22, 8'd34, 8'd36, 8'd38, 8'd50, 8'd52, 8'd54};
    compare_writes("a");
    expect_idle(0, 4);

    // Back-pressure: 5 holds at addr 20, 1 hold at the last pixel.
    no_holds();
    hb[20] = 5;
    hb[63] = 1;
    build_model(0);
    run_frame(0, -1);
    chk("b_done_cycle", act_done, 75);
    chk("b_rd_count", n_rd, 64);
    compare_writes("b");

    // Odd size 7x5.
    no_holds();
    build_model(1);
    run_frame(1, -1);
    chk("c_done_cycle", act_done, 40);
    exp_q = '{8'd16, 8'd18, 8'd20, 8'd30, 8'd32, 8'd34};
    compare_writes("c");

    // Abort at in_addr 30, then a clean frame.
    build_model(0);
    run_frame(0, 30);
    expect_idle(0, 3);
    @(posedge clk);
    #1 rst = 1'b0;
    build_model(0);
    run_frame(0, -1);
    chk("d_done_cycle", act_done, 69);
    exp_q = '{8'd18, 8'd20, 8'd22, 8'd34, 8'd36, 8'd38, 8'd50, 8'd52, 8'd54};
    compare_writes("d");

    // Randomized frames: random image data, holds, drain holds, stray starts.
    for (int f = 0; f < 24; f++) begin
      int k;
      k = int'($urandom_range(0, 1));
      for (int a = 0; a < 64; a++) mem[a] = 8'($urandom_range(0, 255));
      no_holds();
      for (int p = 0; p < 64; p++)
        if ($urandom_range(0, 3) == 0) hb[p] = int'($urandom_range(1, 3));
      build_model(k);
      for (int t = last_rd + 1; t <= done_c; t++) h_t[t] = 1'($urandom_range(0, 1));
      s_t[$urandom_range(1, done_c)] = 1;
      run_frame(k, -1);
      expect_idle(k, int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
